// File: rtl/alu_operand_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_operand_stage : operand A/B select with a one-deep skid output buffer
// Revision 1.0
// ---------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8,
  parameter int C_EXT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       src_a,
  input  logic [2:0]       src_b,
  input  logic [XLEN-1:0]  instr_addr,
  input  logic [31:0]      instr,
  input  logic             instr_len16,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_a,
  output logic [XLEN-1:0]  out_b,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0]  out_a_q, out_b_q, skid_a_q, skid_b_q;
  logic [TAG_W-1:0] out_tag_q, skid_tag_q;

  logic [XLEN-1:0]      pc_inc;
  logic [XLEN-1:0]      sel_a, sel_b;
  logic [3:0][31:0]     imm32;
  logic [3:0][XLEN-1:0] imm;
  logic                 accept, fire;
  logic                 load_out, load_skid, move_skid;
  logic                 opcode_unused;

  assign opcode_unused = ^instr[6:0];

  // 32-bit forms of I, U, JAL and branch immediates, each sign-carrying in bit 31
  assign imm32[0] = {{20{instr[31]}}, instr[31:20]};
  assign imm32[1] = {instr[31:12], 12'b0};
  assign imm32[2] = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm32[3] = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  generate
    if (XLEN > 32) begin : g_sext
      for (genvar k = 0; k < 4; k++) begin : g_imm
        assign imm[k] = {{(XLEN-32){imm32[k][31]}}, imm32[k]};
      end
    end else begin : g_nosext
      assign imm = imm32;
    end
  endgenerate

  assign pc_inc = instr_addr + (((C_EXT != 0) && instr_len16) ? XLEN'(2) : XLEN'(4));

  function automatic logic [XLEN-1:0] pick(
    input logic [2:0]           sel,
    input logic [XLEN-1:0]      reg_data,
    input logic [XLEN-1:0]      pc,
    input logic [XLEN-1:0]      pc_next,
    input logic [3:0][XLEN-1:0] imms
  );
    logic [XLEN-1:0] r;
    case (sel)
      3'b000:  r = '0;
      3'b001:  r = pc_next;
      3'b010:  r = pc;
      3'b011:  r = reg_data;
      3'b100:  r = imms[0];
      3'b101:  r = imms[1];
      3'b110:  r = imms[2];
      default: r = imms[3];
    endcase
    return r;
  endfunction

  assign sel_a = pick(src_a, rs1_data, instr_addr, pc_inc, imm);
  assign sel_b = pick(src_b, rs2_data, instr_addr, pc_inc, imm);

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          load_out = 1'b1;
          state_d  = ST_HALF;
        end
      end
      ST_HALF: begin
        if (accept && !fire) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end else if (!accept && fire) begin
          state_d = ST_EMPTY;
        end else if (accept && fire) begin
          load_out = 1'b1;
        end
      end
      ST_FULL: begin
        if (fire) begin
          move_skid = 1'b1;
          state_d   = ST_HALF;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // A flush drops everything, including whatever is being accepted right now
    if (flush) begin
      state_d   = ST_EMPTY;
      load_out  = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      out_a_q    <= '0;
      out_b_q    <= '0;
      out_tag_q  <= '0;
      skid_a_q   <= '0;
      skid_b_q   <= '0;
      skid_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_out) begin
        out_a_q   <= sel_a;
        out_b_q   <= sel_b;
        out_tag_q <= in_tag;
      end else if (move_skid) begin
        out_a_q   <= skid_a_q;
        out_b_q   <= skid_b_q;
        out_tag_q <= skid_tag_q;
      end
      if (load_skid) begin
        skid_a_q   <= sel_a;
        skid_b_q   <= sel_b;
        skid_tag_q <= in_tag;
      end
    end
  end

  assign out_a   = out_a_q;
  assign out_b   = out_b_q;
  assign out_tag = out_tag_q;

endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and address width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter TAG_W, default 8, giving the width of the sideband tag carried with each operand pair.
REQ-003 The block SHALL have parameter C_EXT, default 0; when 1, 16-bit instruction length handling is enabled.
REQ-004 Port clk SHALL be: input, 1 bit, the sole clock; all state updates on the rising edge.
REQ-005 Port reset SHALL be: input, 1 bit, synchronous, active-high reset.
REQ-006 Port flush SHALL be: input, 1 bit, synchronous discard of all buffered entries.
REQ-007 Port in_valid SHALL be: input, 1 bit, upstream offers an operand request.
REQ-008 Port in_ready SHALL be: output, 1 bit, the stage can accept a request this cycle.
REQ-009 Ports src_a and src_b SHALL be: inputs, 3 bits each, source selects for operand A and operand B.
REQ-010 Port instr_addr SHALL be: input, XLEN bits, PC of the instruction.
REQ-011 Port instr SHALL be: input, 32 bits, the raw instruction word.
REQ-012 Port instr_len16 SHALL be: input, 1 bit, instruction is 16-bit; it is ignored when C_EXT=0.
REQ-013 Ports rs1_data and rs2_data SHALL be: inputs, XLEN bits each, register-file read data.
REQ-014 Port in_tag SHALL be: input, TAG_W bits, opaque sideband passed through unchanged.
REQ-015 Port out_valid SHALL be: output, 1 bit, an operand pair is presented.
REQ-016 Port out_ready SHALL be: input, 1 bit, downstream accepts the presented pair.
REQ-017 Ports out_a, out_b and out_tag SHALL be: outputs, XLEN/XLEN/TAG_W bits, the registered operand pair and its tag.

Function
REQ-018 Each source select SHALL decode as: 000 zero; 001 PC+inc; 010 PC; 011 register data (rs1_data for A, rs2_data for B).
REQ-019 Selects 100..111 SHALL decode as: 100 I-imm instr[31:20]; 101 U-imm instr[31:12]<<12; 110 JAL offset; 111 branch offset.
REQ-020 The immediates and offsets SHALL sign-extend from instr[31] to XLEN, including U-imm when XLEN=64.
REQ-021 The JAL offset SHALL be {instr[31],instr[19:12],instr[20],instr[30:21],0}, and the branch offset SHALL be {instr[31],instr[7],instr[30:25],instr[11:8],0}.
REQ-022 inc SHALL be 2 when C_EXT=1 and instr_len16=1, and 4 otherwise; PC+inc wraps modulo 2^XLEN.
REQ-023 Operand selection SHALL be computed combinationally and captured only on an accept, which is in_valid & in_ready.
REQ-024 Storage SHALL be one output register plus one skid register, tracked by state EMPTY, HALF or FULL.
REQ-025 in_ready SHALL be (state != FULL) and SHALL NOT depend combinationally on out_ready or in_valid.
REQ-026 out_valid SHALL be (state != EMPTY); a fire is out_valid & out_ready.
REQ-027 From EMPTY, an accept SHALL load the output register and move to HALF.
REQ-028 From HALF, accept without fire SHALL load skid and move to FULL; fire without accept SHALL move to EMPTY; accept with fire SHALL load the output register and stay HALF.
REQ-029 From FULL, a fire SHALL move skid to the output register and go to HALF; otherwise the state is held.
REQ-030 Latency SHALL be one cycle: a request accepted in cycle N is presented in cycle N+1.
REQ-031 Throughput SHALL be one pair per cycle while out_ready is held high.
REQ-032 Pairs SHALL emerge in acceptance order with no loss or duplication.
REQ-033 While out_valid=1 and out_ready=0, out_a, out_b and out_tag SHALL hold stable.
REQ-034 flush SHALL force the next state to EMPTY and override a same-cycle accept, whose data is discarded.
REQ-035 All outputs SHALL be X-free for any input combination, since every select code is defined.

Reset
REQ-036 While reset is high, the next state SHALL be EMPTY and out_a, out_b and out_tag SHALL be 0.
REQ-037 reset SHALL take priority over flush, accept and fire.
REQ-038 In the cycle after reset, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-039 An asserted reset in any state, including FULL under backpressure, SHALL discard all entries.

Verification
REQ-040 The bench SHALL cover: XLEN=32, C_EXT=0, src_a=001, instr_addr=0x0000_1000, out_ready=1 -> next cycle out_valid=1, out_a=0x0000_1004.
REQ-041 The bench SHALL cover: C_EXT=1, instr_len16=1, src_a=001, instr_addr=0xFFFF_FFFE -> out_a=0x0000_0000 (wrap).
REQ-042 The bench SHALL cover: XLEN=64, src_b=101, instr=0x8000_0037 -> out_b=0xFFFF_FFFF_8000_0000; src_b=111, instr=0x8000_0063 -> out_b=0xFFFF_FFFF_FFFF_F000.
REQ-043 The bench SHALL cover: out_ready=0, tags 1,2,3 offered back-to-back -> 1 and 2 accepted, in_ready=0 afterwards, 3 held upstream; then out_ready=1 -> tags 1,2,3 out in order, one per cycle.
REQ-044 The bench SHALL cover: FULL with in_valid=1 and flush=1 -> next cycle out_valid=0, in_ready=1, and the flushed tags never appear.
REQ-045 The bench SHALL cover: reset asserted in FULL with out_ready=0 -> next cycle out_valid=0, out_a=out_b=out_tag=0, in_ready=1.
